// File: rtl/uart_pkg.sv
// Shared frame constants and FSM state encoding for the UART TX and RX engines.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered, exact full/empty flags (wrap-bit pointers).
// Pushes while full and pops while empty are silently ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;
    assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_do_push};
    assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_do_pop};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_empty  <= (w_wr_next == w_rd_next);
            // Same index, opposite lap: writer is exactly one wrap ahead.
            r_full   <= (w_wr_next == {~w_rd_next[AW], w_rd_next[AW-1:0]});
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_full_duplex.sv
// Full-duplex 8N1 UART: TX FIFO feeding a serializer, RX deserializer filling an RX FIFO.
// One clock domain; the RX pin is brought in through a two-flop synchronizer.
module uart_full_duplex
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tx_push,
    input  logic [DATA_W-1:0] tx_data_in,
    output logic              tx_fifo_full,
    input  logic              rx_pop,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_fifo_empty,
    output logic              uart_tx_pin,
    input  logic              uart_rx_pin
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);

    // ---------------- TX path ----------------
    uart_state_e       r_tx_state;
    logic [CW-1:0]     r_tx_cnt;
    logic [BW-1:0]     r_tx_bit;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_pin;
    logic              w_tx_empty;
    logic              w_tx_pop;
    logic [DATA_W-1:0] w_tx_head;

    assign w_tx_pop = (r_tx_state == StIdle) && !w_tx_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_push  (tx_push),
        .i_data  (tx_data_in),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (tx_fifo_full),
        .o_empty (w_tx_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tx_state <= StIdle;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_pin   <= 1'b1;
        end else begin
            case (r_tx_state)
                StIdle: begin
                    r_tx_pin <= 1'b1;
                    if (!w_tx_empty) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_pin   <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= StStart;
                    end
                end
                StStart: begin
                    if (r_tx_cnt == BAUD_MAX) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_pin   <= r_tx_shift[0];
                        r_tx_state <= StData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_tx_cnt == BAUD_MAX) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == BIT_MAX) begin
                            r_tx_bit   <= '0;
                            r_tx_pin   <= 1'b1;
                            r_tx_state <= StStop;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_pin   <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_tx_cnt == BAUD_MAX) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == STOP_MAX) begin
                            r_tx_bit   <= '0;
                            r_tx_state <= StIdle;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= StIdle;
            endcase
        end
    end

    assign uart_tx_pin = r_tx_pin;

    // ---------------- RX path ----------------
    logic              r_rx_meta;
    logic              r_rx_sync;
    uart_state_e       r_rx_state;
    logic [CW-1:0]     r_rx_cnt;
    logic [BW-1:0]     r_rx_bit;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_push;
    logic [DATA_W-1:0] r_rx_data;
    logic              w_rx_full;
    logic [DATA_W-1:0] w_rx_head;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_pin;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_state <= StIdle;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_push  <= 1'b0;
        end else begin
            r_rx_push <= 1'b0;
            case (r_rx_state)
                StIdle: begin
                    if (!r_rx_sync) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= StStart;
                    end
                end
                StStart: begin
                    // Mid start bit: a high level here means the edge was a glitch.
                    if (r_rx_cnt == HALF_MAX) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? StIdle : StData;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_rx_cnt == BAUD_MAX) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_W-1:1]};
                        if (r_rx_bit == BIT_MAX) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= StStop;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_rx_cnt == BAUD_MAX) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= StIdle;
                        r_rx_push  <= r_rx_sync && !w_rx_full;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= StIdle;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_push  (r_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (rx_pop),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (rx_fifo_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_data <= '0;
        end else if (rx_pop && !rx_fifo_empty) begin
            r_rx_data <= w_rx_head;
        end
    end

    assign rx_data_out = r_rx_data;

endmodule

// File: tb/tb_uart_full_duplex.sv
// Directed bench for uart_full_duplex: loopback, bit timing, FIFO limits, reset and RX error cases.
module tb_uart_full_duplex;

    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_push = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_full;
    logic       rx_pop = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       tx_pin;
    logic       rx_pin;
    logic       loop_en = 1'b1;
    logic       rx_force = 1'b1;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] fill_vec [20];

    assign rx_pin = loop_en ? tx_pin : rx_force;

    always #5ns clk = ~clk;

    uart_full_duplex #(
        .CLK_PER_BIT (C),
        .FIFO_DEPTH  (16),
        .DATA_W      (8)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .tx_push       (tx_push),
        .tx_data_in    (tx_data),
        .tx_fifo_full  (tx_full),
        .rx_pop        (rx_pop),
        .rx_data_out   (rx_data),
        .rx_fifo_empty (rx_empty),
        .uart_tx_pin   (tx_pin),
        .uart_rx_pin   (rx_pin)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1ns;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        while (tx_full !== 1'b0 && waited < 60 * FRAME) begin
            step(1);
            waited++;
        end
        ok = (tx_full === 1'b0);
        if (ok) begin
            tx_data = b;
            tx_push = 1'b1;
            step(1);
            tx_push = 1'b0;
        end else begin
            vectors++;
            errors++;
            $display("FAIL push_wait: tx_fifo_full=%b after %0d cycles, wanted 0", tx_full, waited);
        end
    endtask

    task automatic pop_byte(output logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        while (rx_empty !== 1'b0 && waited < 3 * FRAME) begin
            step(1);
            waited++;
        end
        ok = (rx_empty === 1'b0);
        if (ok) begin
            rx_pop = 1'b1;
            step(1);
            rx_pop = 1'b0;
        end
        b = rx_data;
    endtask

    task automatic send_manual(input logic [7:0] b, input logic stop);
        rx_force = 1'b0;
        step(C);
        for (int i = 0; i < 8; i++) begin
            rx_force = b[i];
            step(C);
        end
        rx_force = stop;
        step(C);
        rx_force = 1'b1;
        step(C);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        vectors++;
        if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx_pin: got %b, wanted 1", tx_pin); end
        vectors++;
        if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b, wanted 0", tx_full); end
        vectors++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b, wanted 1", rx_empty); end
        vectors++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, wanted 00", rx_data); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_single();
        logic [7:0] pats [6];
        logic [7:0] got;
        bit ok;
        pats = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h80, 8'h01};
        for (int i = 0; i < 6; i++) begin
            push_byte(pats[i], ok);
            pop_byte(got, ok);
            vectors++;
            if (!ok || got !== pats[i]) begin
                errors++;
                $display("FAIL single[%0d]: got %h (arrived=%0d), wanted %h", i, got, ok, pats[i]);
            end
            step(15 * C);
            vectors++;
            if (rx_empty !== 1'b1) begin
                errors++;
                $display("FAIL single_extra[%0d]: rx_fifo_empty=%b, wanted 1", i, rx_empty);
            end
        end
    endtask

    task automatic test_pair();
        logic [7:0] pat;
        logic [7:0] got;
        bit ok;
        int n;
        pat = 8'h12;
        push_byte(8'h12, ok);
        push_byte(8'h34, ok);
        n = 0;
        while (tx_pin !== 1'b0 && n < 4 * C) begin
            step(1);
            n++;
        end
        step(C / 2);
        vectors++;
        if (tx_pin !== 1'b0) begin errors++; $display("FAIL pair_start: got %b, wanted 0", tx_pin); end
        for (int k = 0; k < 8; k++) begin
            step(C);
            vectors++;
            if (tx_pin !== pat[k]) begin
                errors++;
                $display("FAIL pair_bit[%0d]: got %b, wanted %b", k, tx_pin, pat[k]);
            end
        end
        step(C);
        vectors++;
        if (tx_pin !== 1'b1) begin errors++; $display("FAIL pair_stop: got %b, wanted 1", tx_pin); end
        n = C / 2 + 9 * C;
        while (tx_pin !== 1'b0 && n < 12 * C) begin
            step(1);
            n++;
        end
        vectors++;
        if (n < 10 * C || n > 10 * C + 2) begin
            errors++;
            $display("FAIL pair_gap: next start %0d cycles after first, wanted %0d..%0d",
                     n, 10 * C, 10 * C + 2);
        end
        pop_byte(got, ok);
        vectors++;
        if (!ok || got !== 8'h12) begin errors++; $display("FAIL pair_first: got %h, wanted 12", got); end
        pop_byte(got, ok);
        vectors++;
        if (!ok || got !== 8'h34) begin errors++; $display("FAIL pair_second: got %h, wanted 34", got); end
    endtask

    task automatic test_fill();
        logic [7:0] got;
        bit ok;
        fill_vec = '{8'h3C, 8'h9E, 8'h07, 8'hD1, 8'h62, 8'hF0, 8'h1B, 8'hA8, 8'h4D, 8'hE3,
                     8'h75, 8'h2A, 8'hC9, 8'h58, 8'hB6, 8'h0F, 8'h93, 8'h6E, 8'hE1, 8'h24};
        for (int i = 0; i < 20; i++) begin
            push_byte(fill_vec[i], ok);
            if (i == 15) begin
                vectors++;
                if (tx_full !== 1'b0) begin errors++; $display("FAIL fill_not_full: got %b, wanted 0", tx_full); end
            end
            if (i == 16) begin
                vectors++;
                if (tx_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b, wanted 1", tx_full); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            pop_byte(got, ok);
            vectors++;
            if (!ok || got !== fill_vec[i]) begin
                errors++;
                $display("FAIL fill[%0d]: got %h (arrived=%0d), wanted %h", i, got, ok, fill_vec[i]);
            end
        end
    endtask

    task automatic test_full_empty();
        logic [7:0] got;
        bit ok;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h30 + 8'(i), ok);
        end
        vectors++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL over_full: got %b, wanted 1", tx_full); end
        tx_data = 8'hEE;
        tx_push = 1'b1;
        step(1);
        tx_push = 1'b0;
        for (int i = 0; i < 17; i++) begin
            pop_byte(got, ok);
            vectors++;
            if (!ok || got !== 8'h30 + 8'(i)) begin
                errors++;
                $display("FAIL over[%0d]: got %h (arrived=%0d), wanted %h", i, got, ok, 8'h30 + 8'(i));
            end
        end
        step(3 * FRAME);
        vectors++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL over_rejected: rx_fifo_empty=%b, wanted 1", rx_empty); end
        rx_pop = 1'b1;
        step(1);
        rx_pop = 1'b0;
        vectors++;
        if (rx_data !== 8'h40) begin errors++; $display("FAIL pop_empty_hold: got %h, wanted 40", rx_data); end
        vectors++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL pop_empty_flag: got %b, wanted 1", rx_empty); end
    endtask

    task automatic test_rx_errors();
        logic [7:0] got;
        bit ok;
        rx_force = 1'b1;
        loop_en  = 1'b0;
        step(4);
        rx_force = 1'b0;
        step(1);
        rx_force = 1'b1;
        step(3 * FRAME);
        vectors++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch: rx_fifo_empty=%b, wanted 1", rx_empty); end
        send_manual(8'h5A, 1'b0);
        step(2 * FRAME);
        vectors++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL framing: rx_fifo_empty=%b, wanted 1", rx_empty); end
        send_manual(8'hA5, 1'b1);
        pop_byte(got, ok);
        vectors++;
        if (!ok || got !== 8'hA5) begin errors++; $display("FAIL manual_frame: got %h, wanted a5", got); end
        loop_en = 1'b1;
        step(2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        bit ok;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'hB0 ^ 8'(i), ok);
        end
        step(15);
        rst_n = 1'b0;
        #1ns;
        vectors++;
        if (tx_pin !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_pin: got %b, wanted 1", tx_pin); end
        vectors++;
        if (tx_full !== 1'b0) begin errors++; $display("FAIL rst_mid_full: got %b, wanted 0", tx_full); end
        vectors++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b, wanted 1", rx_empty); end
        vectors++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h, wanted 00", rx_data); end
        #499ns;
        rst_n = 1'b1;
        step(2 * FRAME);
        vectors++;
        if (rx_empty !== 1'b1 || tx_pin !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet: rx_fifo_empty=%b tx_pin=%b, wanted 1 1", rx_empty, tx_pin);
        end
        push_byte(8'hCC, ok);
        pop_byte(got, ok);
        vectors++;
        if (!ok || got !== 8'hCC) begin errors++; $display("FAIL rst_mid_cc: got %h, wanted cc", got); end
    endtask

    task automatic test_stream();
        logic [7:0] q [$];
        logic [7:0] got;
        logic [7:0] exp;
        bit ok;
        fork
            begin
                bit pok;
                for (int i = 0; i < 1000; i++) begin
                    push_byte(8'(i * 37 + 11), pok);
                    if (!pok) break;
                    q.push_back(8'(i * 37 + 11));
                end
            end
            begin
                bit rok;
                logic [7:0] b;
                logic [7:0] e;
                for (int i = 0; i < 1000; i++) begin
                    pop_byte(b, rok);
                    e = (q.size() > 0) ? q.pop_front() : 8'hxx;
                    vectors++;
                    if (!rok || b !== e) begin
                        errors++;
                        $display("FAIL stream[%0d]: got %h (arrived=%0d), wanted %h", i, b, rok, e);
                        if (!rok) break;
                    end
                end
            end
        join
        for (int i = 0; i < 2; i++) begin
            exp = (i == 0) ? 8'hFF : 8'h00;
            push_byte(exp, ok);
            pop_byte(got, ok);
            vectors++;
            if (!ok || got !== exp) begin errors++; $display("FAIL stream_tail[%0d]: got %h, wanted %h", i, got, exp); end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_fill();
        test_full_empty();
        test_rx_errors();
        test_reset_mid();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
